// File: rtl/mux2_rr_pkg.sv
// Shared types and default widths for the two-channel round-robin mux stage.
package mux2_rr_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

endpackage : mux2_rr_pkg

// File: rtl/mux2.sv
// Plain two-input datapath multiplexer: y = s ? b : a.
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule : mux2

// File: rtl/mux2_rr_stage.sv
// Round-robin arbiter steering mux2, with a single-entry valid/ready output
// buffer and per-source transfer counters.
module mux2_rr_stage
  import mux2_rr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_src,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  buf_state_t       state, state_nxt;
  src_t             last, sel_q, grant, sel_c;
  logic             any_valid, can_accept, xfer;
  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] y_data_q;
  src_t             y_src_q;
  logic [CNT_W-1:0] a_cnt, b_cnt;

  mux2 #(.WIDTH(WIDTH)) u_mux2 (
    .a (a_data),
    .b (b_data),
    .s (sel_c),
    .y (mux_y)
  );

  // Arbitration: a contested cycle goes to whichever channel was not served last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    grant     = SRC_A;
    any_valid = a_valid | b_valid;
    if (a_valid && b_valid) begin
      grant = (last == SRC_A) ? SRC_B : SRC_A;
    end else if (b_valid) begin
      grant = SRC_B;
    end
    sel_c = any_valid ? grant : sel_q;
  end

  // Readies are forced low while reset is held so nothing transfers into a buffer being cleared.
  assign can_accept = (state == EMPTY) || y_ready;
  assign a_ready    = reset_n && can_accept && a_valid && (grant == SRC_A);
  assign b_ready    = reset_n && can_accept && b_valid && (grant == SRC_B);
  assign xfer       = a_ready || b_ready;

  always_comb begin
    state_nxt = state;
    if (xfer) begin
      state_nxt = FULL;
    end else if (state == FULL && y_ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled only at the clock edge), and state uses non-blocking assignments.
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q    <= SRC_A;
      last     <= SRC_B;
      y_data_q <= '0;
      y_src_q  <= SRC_A;
      a_cnt    <= '0;
      b_cnt    <= '0;
    end else begin
      sel_q <= sel_c;
      if (xfer) begin
        y_data_q <= mux_y;
        y_src_q  <= sel_c;
        last     <= sel_c;
        if (sel_c == SRC_A) begin
          a_cnt <= a_cnt + CNT_W'(1);
        end else begin
          b_cnt <= b_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign sel     = sel_c;
  assign y_data  = y_data_q;
  assign y_src   = y_src_q;
  assign y_valid = (state == FULL);
  assign a_count = a_cnt;
  assign b_count = b_cnt;

endmodule : mux2_rr_stage
